// File: rtl/layer_controller.sv
// Sequencer for one fully-connected layer: walks neurons and input chunks,
// driving weight/bias addresses and MAC/bias/emit strobes for the datapath.
module layer_controller #(
  parameter int ADDRSIZE    = 5,
  parameter int INPUTSIZE   = 4,
  parameter int NEURONCOUNT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [ADDRSIZE-1:0] out_index,
  output logic [ADDRSIZE-1:0] wt_addr,
  output logic [ADDRSIZE-1:0] bias_addr,
  output logic                mac_clr,
  output logic                mac_en,
  output logic                bias_add,
  output logic                busy,
  output logic                done
);

  localparam int CW = (INPUTSIZE > 1) ? $clog2(INPUTSIZE) : 1;
  localparam logic [CW-1:0]       LAST_CHUNK  = CW'(INPUTSIZE - 1);
  localparam logic [ADDRSIZE-1:0] LAST_NEURON = ADDRSIZE'(NEURONCOUNT - 1);
  localparam logic [ADDRSIZE-1:0] ISZ         = ADDRSIZE'(INPUTSIZE);

  typedef enum logic [2:0] {IDLE, FETCH, MAC, BIAS, EMIT, FIN} state_t;

  state_t               state_q, state_d;
  logic [ADDRSIZE-1:0]  neuron_q, neuron_d;
  logic [CW-1:0]        chunk_q, chunk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      neuron_q <= '0;
      chunk_q  <= '0;
    end else begin
      state_q  <= state_d;
      neuron_q <= neuron_d;
      chunk_q  <= chunk_d;
    end
  end

  // Counters saturate at their last value rather than wrapping; they are
  // cleared explicitly on the transitions that start a new neuron or pass.
  always_comb begin
    state_d  = state_q;
    neuron_d = neuron_q;
    chunk_d  = chunk_q;
    if (abort) begin
      state_d  = IDLE;
      neuron_d = '0;
      chunk_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d  = FETCH;
          neuron_d = '0;
          chunk_d  = '0;
        end
        FETCH: state_d = MAC;
        MAC: if (in_valid) begin
          if (chunk_q == LAST_CHUNK) begin
            state_d = BIAS;
          end else begin
            chunk_d = chunk_q + CW'(1);
            state_d = FETCH;
          end
        end
        BIAS: state_d = EMIT;
        EMIT: if (out_ready) begin
          if (neuron_q == LAST_NEURON) begin
            state_d = FIN;
          end else begin
            neuron_d = neuron_q + ADDRSIZE'(1);
            chunk_d  = '0;
            state_d  = FETCH;
          end
        end
        FIN: begin
          state_d  = IDLE;
          neuron_d = '0;
          chunk_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters are zero in IDLE, so addresses fall to zero there and in reset.
  always_comb begin
    in_ready  = (state_q == MAC);
    mac_en    = (state_q == MAC) & in_valid;
    mac_clr   = (state_q == FETCH) & (chunk_q == '0);
    bias_add  = (state_q == BIAS);
    out_valid = (state_q == EMIT);
    out_index = (state_q == EMIT) ? neuron_q : '0;
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    wt_addr   = neuron_q * ISZ + ADDRSIZE'(chunk_q);
    bias_addr = neuron_q;
  end

endmodule

// File: tb/tb_layer_controller.sv
// Bench for layer_controller: schedule-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_layer_controller;
  localparam int AS = 5, IS = 4, NC = 8;
  localparam int K_FETCH = 1, K_MAC = 2, K_BIAS = 3, K_EMIT = 4, K_FIN = 5;

  logic clk = 0, rst = 0;
  logic start = 0, abort = 0, in_valid = 1, out_ready = 1;
  logic in_ready, out_valid, mac_clr, mac_en, bias_add, busy, done;
  logic [AS-1:0] out_index, wt_addr, bias_addr;

  logic s1_start = 0, s1_abort = 0, s1_iv = 1, s1_or = 1;
  logic u1_in_ready, u1_out_valid, u1_mac_clr, u1_mac_en, u1_bias_add, u1_busy, u1_done;
  logic [0:0] u1_out_index, u1_wt_addr, u1_bias_addr;

  int errors = 0, checks = 0, done_cnt = 0;
  int m_pos = -1;
  int s_kind[$], s_n[$], s_c[$];

  always #5 clk = ~clk;

  layer_controller #(.ADDRSIZE(AS), .INPUTSIZE(IS), .NEURONCOUNT(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .out_valid(out_valid), .out_index(out_index), .wt_addr(wt_addr),
    .bias_addr(bias_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .bias_add(bias_add), .busy(busy), .done(done));

  layer_controller #(.ADDRSIZE(1), .INPUTSIZE(1), .NEURONCOUNT(1)) u1 (
    .clk(clk), .rst(rst), .start(s1_start), .abort(s1_abort),
    .in_valid(s1_iv), .in_ready(u1_in_ready), .out_ready(s1_or),
    .out_valid(u1_out_valid), .out_index(u1_out_index), .wt_addr(u1_wt_addr),
    .bias_addr(u1_bias_addr), .mac_clr(u1_mac_clr), .mac_en(u1_mac_en),
    .bias_add(u1_bias_add), .busy(u1_busy), .done(u1_done));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit at_step(input int k, input int n, input int c);
    return m_pos >= 0 && s_kind[m_pos] == k && s_n[m_pos] == n && (c < 0 || s_c[m_pos] == c);
  endfunction

  // A pass is a fixed list of steps; the model only tracks its position in it.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_pos <= -1;
    else if (abort) m_pos <= -1;
    else if (m_pos < 0) begin
      if (start) m_pos <= 0;
    end else begin
      case (s_kind[m_pos])
        K_MAC:   if (in_valid) m_pos <= m_pos + 1;
        K_EMIT:  if (out_ready) m_pos <= m_pos + 1;
        K_FIN:   m_pos <= -1;
        default: m_pos <= m_pos + 1;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    int k, n, c;
    k = (m_pos >= 0) ? s_kind[m_pos] : 0;
    n = (m_pos >= 0) ? s_n[m_pos] : 0;
    c = (m_pos >= 0) ? s_c[m_pos] : 0;
    if (done) done_cnt++;
    chk("m_busy", busy, m_pos >= 0);
    chk("m_in_ready", in_ready, k == K_MAC);
    chk("m_mac_en", mac_en, k == K_MAC && in_valid);
    chk("m_mac_clr", mac_clr, k == K_FETCH && c == 0);
    chk("m_bias_add", bias_add, k == K_BIAS);
    chk("m_out_valid", out_valid, k == K_EMIT);
    chk("m_done", done, k == K_FIN);
    if (k == K_FETCH || k == K_MAC) chk("m_wt_addr", wt_addr, (n * IS + c) % 32);
    if (k >= K_FETCH && k <= K_EMIT) chk("m_bias_addr", bias_addr, n);
    if (k == K_EMIT) chk("m_out_index", out_index, n);
    if (!rst) chk("m_rst_addr", {wt_addr, bias_addr, out_index}, 0);
  end

  task automatic wait_for(input int k, input int n, input int c, input string nm);
    int t = 0;
    while (!at_step(k, n, c) && t < 300) begin step_cyc(); t++; end
    chk(nm, t < 300, 1);
  endtask

  // mode: 0 plain, 1 start pulses while busy, 2 in_valid stall, 3 out_ready stall
  task automatic run_pass(input int mode, input int exp_cyc, input string nm);
    int cnt, hs, macs, stall, restore_at;
    bit stalled;
    hs = 0; macs = 0; stall = 0; stalled = 0; restore_at = -1;
    start = 1; step_cyc(); start = 0;
    chk({nm, "_first_addr"}, wt_addr, 0);
    chk({nm, "_first_clr"}, mac_clr, 1);
    cnt = 1;
    while (!done && cnt < 300) begin
      if (mode == 2 && !stalled && at_step(K_MAC, 2, 1)) begin in_valid = 0; stall = 5; stalled = 1; end
      if (mode == 3 && !stalled && at_step(K_EMIT, 7, -1)) begin out_ready = 0; stall = 3; stalled = 1; end
      start = (mode == 1 && (cnt == 5 || cnt == 40));
      #1;
      if (stall > 0 && mode == 2) begin
        chk({nm, "_hold_addr"}, wt_addr, 9);
        chk({nm, "_hold_mac_en"}, mac_en, 0);
        chk({nm, "_hold_in_ready"}, in_ready, 1);
      end
      if (stall > 0 && mode == 3) begin
        chk({nm, "_hold_valid"}, out_valid, 1);
        chk({nm, "_hold_index"}, out_index, 7);
        chk({nm, "_hold_done"}, done, 0);
      end
      if (mac_en) begin chk({nm, "_wt_seq"}, wt_addr, macs); macs++; end
      if (out_valid && out_ready) begin chk({nm, "_idx_seq"}, out_index, hs); hs++; end
      step_cyc(); cnt++;
      if (stall > 0) begin
        stall--;
        if (stall == 0) begin in_valid = 1; out_ready = 1; restore_at = cnt; end
      end
    end
    start = 0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_cycles"}, cnt, exp_cyc);
    chk({nm, "_handshakes"}, hs, 8);
    chk({nm, "_macs"}, macs, 32);
    if (mode == 3) chk({nm, "_done_lag"}, cnt - restore_at, 1);
    step_cyc();
    chk({nm, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int d0;
    for (int n = 0; n < NC; n++) begin
      for (int c = 0; c < IS; c++) begin
        s_kind.push_back(K_FETCH); s_n.push_back(n); s_c.push_back(c);
        s_kind.push_back(K_MAC);   s_n.push_back(n); s_c.push_back(c);
      end
      s_kind.push_back(K_BIAS); s_n.push_back(n); s_c.push_back(IS - 1);
      s_kind.push_back(K_EMIT); s_n.push_back(n); s_c.push_back(IS - 1);
    end
    s_kind.push_back(K_FIN); s_n.push_back(NC - 1); s_c.push_back(IS - 1);
    chk("sched_len", s_kind.size(), 81);

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_addrs", {wt_addr, bias_addr}, 0);
    chk("rst_strobes", {in_ready, out_valid, mac_clr, mac_en, bias_add, done}, 0);
    step_cyc(); rst = 1; step_cyc();

    run_pass(0, 81, "plain");
    run_pass(1, 81, "start_busy");
    run_pass(2, 86, "in_stall");
    run_pass(3, 84, "out_stall");

    start = 1; abort = 1; step_cyc(); start = 0; abort = 0;
    chk("start_abort_idle", busy, 0);

    d0 = done_cnt;
    start = 1; step_cyc(); start = 0;
    wait_for(K_MAC, 4, -1, "reach_mac_n4");
    abort = 1; step_cyc(); abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (3) step_cyc();
    chk("abort_no_done", done_cnt, d0);
    run_pass(0, 81, "restart");

    d0 = done_cnt;
    start = 1; step_cyc(); start = 0;
    wait_for(K_BIAS, 3, -1, "reach_bias");
    chk("bias_seen", bias_add, 1);
    rst = 0; #1;
    chk("arst_ctrl", {busy, in_ready, out_valid, mac_clr, mac_en, bias_add, done}, 0);
    chk("arst_addrs", {wt_addr, bias_addr, out_index}, 0);
    repeat (2) step_cyc();
    rst = 1; start = 1; step_cyc(); start = 0;
    chk("post_rst_busy", busy, 1);
    chk("post_rst_clr", mac_clr, 1);
    chk("post_rst_addr", wt_addr, 0);
    chk("rst_no_done", done_cnt, d0);
    abort = 1; step_cyc(); abort = 0;

    s1_start = 1; step_cyc(); s1_start = 0;
    chk("u1_fetch", {u1_mac_clr, u1_mac_en, u1_bias_add, u1_out_valid, u1_done}, 5'b10000);
    step_cyc();
    chk("u1_mac", {u1_mac_clr, u1_mac_en, u1_bias_add, u1_out_valid, u1_done}, 5'b01000);
    step_cyc();
    chk("u1_bias", {u1_mac_clr, u1_mac_en, u1_bias_add, u1_out_valid, u1_done}, 5'b00100);
    step_cyc();
    chk("u1_emit", {u1_mac_clr, u1_mac_en, u1_bias_add, u1_out_valid, u1_done}, 5'b00010);
    step_cyc();
    chk("u1_fin", {u1_mac_clr, u1_mac_en, u1_bias_add, u1_out_valid, u1_done}, 5'b00001);
    step_cyc();
    chk("u1_idle", u1_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
